// File: rtl/rc4_prga_stream.sv
// RC4 keystream generator (PRGA) with ciphertext decrypt.
// Walks a pre-scheduled 256-byte S memory, swaps S[i]/S[j] per byte, XORs
// the keystream byte with a ciphertext ROM byte and writes the plaintext to
// a result RAM. Optionally rejects the run on the first non-printable
// plaintext byte (space or lowercase letters only), reporting where it
// stopped so a key-search controller can discard the candidate key.
//
// Memory read model: the S memory and ROM return data RD_LAT cycles after
// the address is first presented. Read addresses are held for the whole
// read state and data is captured on its last cycle.
module rc4_prga_stream #(
    parameter int MSG_LEN  = 32,
    parameter int ADDR_W   = 5,
    parameter int RD_LAT   = 2,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   msg_len,
    input  logic [7:0]        s_read_data,
    input  logic [7:0]        rom_read_data,
    output logic [7:0]        s_address,
    output logic              s_write,
    output logic [7:0]        s_write_data,
    output logic [ADDR_W-1:0] rom_address,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write,
    output logic [7:0]        ram_write_data,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [ADDR_W-1:0] fail_index
);

    localparam int               LEN_W    = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MSG_LEN);
    localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INC_I  = 4'd1,
        ST_RD_SI  = 4'd2,
        ST_CALC_J = 4'd3,
        ST_RD_SJ  = 4'd4,
        ST_WR_J   = 4'd5,
        ST_WR_I   = 4'd6,
        ST_RD_F   = 4'd7,
        ST_CHECK  = 4'd8,
        ST_WR_OUT = 4'd9,
        ST_NEXT   = 4'd10,
        ST_DONE   = 4'd11
    } state_e;

    // Accepted plaintext alphabet: space and 'a'..'z'.
    function automatic logic is_printable(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        romk_q, romk_d;
    logic [7:0]        f_q, f_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] fail_q, fail_d;

    logic [LEN_W-1:0]  len_clamped;
    logic              last_rd;
    logic              k_last;
    logic [7:0]        plain;

    assign len_clamped = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
    assign last_rd     = (lat_cnt_q == LAT_LAST);
    assign k_last      = ({1'b0, k_q} == (len_q - LEN_W'(1)));
    assign plain       = f_q ^ romk_q;

    // State register and read-wait counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state, datapath next values and memory-interface strobes.
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = 2'd0;
        i_d          = i_q;
        j_d          = j_q;
        k_d          = k_q;
        len_d        = len_q;
        si_d         = si_q;
        sj_d         = sj_q;
        romk_d       = romk_q;
        f_d          = f_q;
        wdata_d      = wdata_q;
        valid_d      = valid_q;
        fail_d       = fail_q;
        s_address    = 8'd0;
        s_write      = 1'b0;
        s_write_data = 8'd0;
        ram_write    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = len_clamped;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = '0;
                    valid_d = 1'b0;
                    fail_d  = '0;
                    if (len_clamped == '0) begin
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_INC_I;
                    end
                end
            end
            ST_INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = ST_RD_SI;
            end
            ST_RD_SI: begin
                // ROM fetch for byte k overlaps the S[i] read.
                s_address = i_q;
                if (last_rd) begin
                    si_d    = s_read_data;
                    romk_d  = rom_read_data;
                    state_d = ST_CALC_J;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_CALC_J: begin
                j_d     = j_q + si_q;
                state_d = ST_RD_SJ;
            end
            ST_RD_SJ: begin
                s_address = j_q;
                if (last_rd) begin
                    sj_d    = s_read_data;
                    state_d = ST_WR_J;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_WR_J: begin
                s_address    = j_q;
                s_write      = 1'b1;
                s_write_data = si_q;
                state_d      = ST_WR_I;
            end
            ST_WR_I: begin
                // Written second so that i==j leaves S[i] with its original value.
                s_address    = i_q;
                s_write      = 1'b1;
                s_write_data = sj_q;
                state_d      = ST_RD_F;
            end
            ST_RD_F: begin
                s_address = si_q + sj_q;
                if (last_rd) begin
                    f_d     = s_read_data;
                    state_d = ST_CHECK;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_CHECK: begin
                wdata_d = plain;
                if (CHECK_EN && !is_printable(plain)) begin
                    valid_d = 1'b0;
                    fail_d  = k_q;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WR_OUT;
                end
            end
            ST_WR_OUT: begin
                ram_write = 1'b1;
                state_d   = ST_NEXT;
            end
            ST_NEXT: begin
                if (k_last) begin
                    valid_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + ADDR_W'(1);
                    state_d = ST_INC_I;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: indices, captured reads, result and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            k_q     <= '0;
            len_q   <= '0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            romk_q  <= 8'd0;
            f_q     <= 8'd0;
            wdata_q <= 8'd0;
            valid_q <= 1'b0;
            fail_q  <= '0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            len_q   <= len_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            romk_q  <= romk_d;
            f_q     <= f_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
        end
    end

    assign rom_address    = k_q;
    assign ram_address    = k_q;
    assign ram_write_data = wdata_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign valid          = valid_q;
    assign fail_index     = fail_q;

endmodule

// File: tb/tb_rc4_prga_stream.sv
// Bench for rc4_prga_stream. Two instances: unit 0 is RD_LAT=2 with the
// printable check enabled, unit 1 is RD_LAT=1 with the check disabled.
// Each unit has its own S memory, ciphertext ROM and result RAM. Expected
// results come from a plain RC4 PRGA model working on integer arrays.
module tb_rc4_prga_stream;

    localparam int ADDR_W = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // Stimulus and per-unit views of the DUT ports.
    logic              start_v [2];
    logic [ADDR_W:0]   len_v   [2];
    logic [7:0]        a_s_rd, a_rom_rd, b_s_rd, b_rom_rd;

    logic [7:0]        a_s_addr, b_s_addr, a_s_wd, b_s_wd, a_ram_wd, b_ram_wd;
    logic              a_s_we, b_s_we, a_ram_we, b_ram_we;
    logic [ADDR_W-1:0] a_rom_addr, b_rom_addr, a_ram_addr, b_ram_addr, a_fail, b_fail;
    logic              a_busy, b_busy, a_done, b_done, a_valid, b_valid;

    logic [7:0]        s_addr_v   [2];
    logic [7:0]        s_wd_v     [2];
    logic [7:0]        ram_wd_v   [2];
    logic              s_we_v     [2];
    logic              ram_we_v   [2];
    logic [ADDR_W-1:0] rom_addr_v [2];
    logic [ADDR_W-1:0] ram_addr_v [2];
    logic [ADDR_W-1:0] fail_v     [2];
    logic              busy_v     [2];
    logic              done_v     [2];
    logic              valid_v    [2];

    rc4_prga_stream #(.MSG_LEN(32), .ADDR_W(ADDR_W), .RD_LAT(2), .CHECK_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .msg_len(len_v[0]),
        .s_read_data(a_s_rd), .rom_read_data(a_rom_rd),
        .s_address(a_s_addr), .s_write(a_s_we), .s_write_data(a_s_wd),
        .rom_address(a_rom_addr), .ram_address(a_ram_addr), .ram_write(a_ram_we),
        .ram_write_data(a_ram_wd), .busy(a_busy), .done(a_done), .valid(a_valid),
        .fail_index(a_fail)
    );

    rc4_prga_stream #(.MSG_LEN(32), .ADDR_W(ADDR_W), .RD_LAT(1), .CHECK_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .msg_len(len_v[1]),
        .s_read_data(b_s_rd), .rom_read_data(b_rom_rd),
        .s_address(b_s_addr), .s_write(b_s_we), .s_write_data(b_s_wd),
        .rom_address(b_rom_addr), .ram_address(b_ram_addr), .ram_write(b_ram_we),
        .ram_write_data(b_ram_wd), .busy(b_busy), .done(b_done), .valid(b_valid),
        .fail_index(b_fail)
    );

    always_comb begin
        s_addr_v[0] = a_s_addr;     s_addr_v[1] = b_s_addr;
        s_wd_v[0] = a_s_wd;         s_wd_v[1] = b_s_wd;
        ram_wd_v[0] = a_ram_wd;     ram_wd_v[1] = b_ram_wd;
        s_we_v[0] = a_s_we;         s_we_v[1] = b_s_we;
        ram_we_v[0] = a_ram_we;     ram_we_v[1] = b_ram_we;
        rom_addr_v[0] = a_rom_addr; rom_addr_v[1] = b_rom_addr;
        ram_addr_v[0] = a_ram_addr; ram_addr_v[1] = b_ram_addr;
        fail_v[0] = a_fail;         fail_v[1] = b_fail;
        busy_v[0] = a_busy;         busy_v[1] = b_busy;
        done_v[0] = a_done;         done_v[1] = b_done;
        valid_v[0] = a_valid;       valid_v[1] = b_valid;
    end

    // Memory models. Unit 0 has one read register (latency 2 as seen by the
    // DUT's capture point), unit 1 reads combinationally (latency 1).
    logic [7:0] s_mem   [2][256];
    logic [7:0] rom_mem [2][32];
    logic [7:0] ram_mem [2][32];
    int         s_wr_cnt   [2] = '{0, 0};
    int         ram_wr_cnt [2] = '{0, 0};

    logic       load_req = 1'b0;
    int         ld_g     = 0;
    logic [7:0] ld_s   [256];
    logic [7:0] ld_rom [32];

    always @(posedge clk) begin
        if (load_req) begin
            for (int x = 0; x < 256; x++) s_mem[ld_g][x] <= ld_s[x];
            for (int x = 0; x < 32; x++) begin
                rom_mem[ld_g][x] <= ld_rom[x];
                ram_mem[ld_g][x] <= 8'h00;
            end
        end else begin
            for (int g = 0; g < 2; g++) begin
                if (s_we_v[g]) begin
                    s_mem[g][s_addr_v[g]] <= s_wd_v[g];
                    s_wr_cnt[g] <= s_wr_cnt[g] + 1;
                end
                if (ram_we_v[g]) begin
                    ram_mem[g][ram_addr_v[g]] <= ram_wd_v[g];
                    ram_wr_cnt[g] <= ram_wr_cnt[g] + 1;
                end
            end
        end
        a_s_rd   <= s_mem[0][s_addr_v[0]];
        a_rom_rd <= rom_mem[0][rom_addr_v[0]];
    end

    assign b_s_rd   = s_mem[1][s_addr_v[1]];
    assign b_rom_rd = rom_mem[1][rom_addr_v[1]];

    // Checking.
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    int         ms      [2][256];
    logic [7:0] rom_img [2][32];
    int         tmp_s   [256];
    int         ks      [32];
    logic [7:0] exp_ram [32];
    int         exp_wr, exp_bytes, exp_cycle, exp_fail;
    bit         exp_valid;
    int         last_cycle;

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : 1;
    endfunction

    function automatic bit printable(input int p);
        return (p == 'h20) || (p >= 'h61 && p <= 'h7A);
    endfunction

    // Plain RC4 PRGA over the model's copy of S; optionally commits the
    // resulting S back to the model.
    task automatic prga_model(input int g, input int len, input bit use_check, input bit commit);
        int n, i, j, t, p, per;
        n = (len > 32) ? 32 : len;
        per = 7 + 3 * lat_of(g);
        for (int x = 0; x < 256; x++) tmp_s[x] = ms[g][x];
        i = 0; j = 0;
        exp_wr = 0; exp_bytes = 0; exp_valid = 1'b1; exp_fail = 0;
        exp_cycle = n * per + 1;
        for (int k = 0; k < n; k++) begin
            i = (i + 1) % 256;
            j = (j + tmp_s[i]) % 256;
            t = tmp_s[i]; tmp_s[i] = tmp_s[j]; tmp_s[j] = t;
            ks[k] = tmp_s[(tmp_s[i] + tmp_s[j]) % 256];
            exp_bytes++;
            p = ks[k] ^ int'(rom_img[g][k]);
            if (use_check && !printable(p)) begin
                exp_valid = 1'b0;
                exp_fail  = k;
                exp_cycle = k * per + per - 1;
                break;
            end
            exp_ram[k] = 8'(p);
            exp_wr++;
        end
        if (commit) for (int x = 0; x < 256; x++) ms[g][x] = tmp_s[x];
    endtask

    task automatic load(input int g);
        @(negedge clk);
        ld_g = g;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        for (int x = 0; x < 256; x++) ms[g][x] = int'(ld_s[x]);
        for (int x = 0; x < 32; x++) rom_img[g][x] = ld_rom[x];
    endtask

    task automatic identity_s();
        for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
    endtask

    task automatic random_s();
        logic [7:0] t;
        int r;
        identity_s();
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(0, x);
            t = ld_s[x]; ld_s[x] = ld_s[r]; ld_s[r] = t;
        end
    endtask

    // Ciphertext that decrypts to printable text, optionally with one bad byte.
    task automatic build_rom(input int g, input int len, input int bad_at);
        int r;
        logic [7:0] p;
        prga_model(g, len, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) begin
            r = $urandom_range(0, 26);
            p = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            if (k == bad_at) begin
                p = 8'($urandom_range(0, 255));
                while (printable(int'(p))) p = 8'($urandom_range(0, 255));
            end
            ld_rom[k] = (k < exp_bytes) ? (8'(ks[k]) ^ p) : 8'($urandom_range(0, 255));
        end
    endtask

    // One run on unit g, checked against the model.
    task automatic run(input int g, input int len, input bit hold);
        int c, swr0, rwr0, mm;
        bit seen;
        prga_model(g, len, (g == 0), 1'b1);
        swr0 = s_wr_cnt[g];
        rwr0 = ram_wr_cnt[g];
        @(negedge clk);
        start_v[g] = 1'b1;
        len_v[g]   = 6'(len);
        c = 0; seen = 1'b0; last_cycle = -1;
        while (c < 2000 && !seen) begin
            @(negedge clk);
            c++;
            if (!hold) start_v[g] = 1'b0;
            if (c == 2 && exp_bytes > 0) begin
                check("first_si_addr", s_addr_v[g], 1);
                check("first_rom_addr", rom_addr_v[g], 0);
            end
            if (done_v[g]) begin
                seen = 1'b1;
                last_cycle = c;
            end
        end
        start_v[g] = 1'b0;
        check("done_cycle", last_cycle, exp_cycle);
        check("valid", valid_v[g], exp_valid);
        check("fail_index", fail_v[g], exp_fail);
        check("busy_in_done", busy_v[g], 1);
        @(negedge clk);
        check("done_pulse", done_v[g], 0);
        check("busy_idle", busy_v[g], 0);
        check("valid_hold", valid_v[g], exp_valid);
        check("ram_writes", ram_wr_cnt[g] - rwr0, exp_wr);
        check("s_writes", s_wr_cnt[g] - swr0, 2 * exp_bytes);
        mm = 0;
        for (int k = 0; k < exp_wr; k++) if (ram_mem[g][k] !== exp_ram[k]) mm++;
        check("ram_data_mism", mm, 0);
        mm = 0;
        for (int x = 0; x < 256; x++) if (s_mem[g][x] !== 8'(ms[g][x])) mm++;
        check("s_mem_mism", mm, 0);
    endtask

    initial begin
        int len, bad, g;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        len_v[0] = '0;     len_v[1] = '0;

        // Reset state.
        #1 rst_n = 1'b0;
        #2;
        check("rst_data", {a_s_addr, a_s_wd, a_ram_wd}, 0);
        check("rst_ctrl", {a_s_we, a_rom_addr, a_ram_addr, a_ram_we, a_busy, a_done, a_valid, a_fail}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Identity S, zero ROM, unchecked unit at RD_LAT=1.
        identity_s();
        for (int x = 0; x < 32; x++) ld_rom[x] = 8'h00;
        load(1);
        run(1, 3, 1'b0);
        check("tp1_cycle", last_cycle, 31);
        check("tp1_ram0", ram_mem[1][0], 8'h02);
        check("tp1_ram1", ram_mem[1][1], 8'h05);
        check("tp1_ram2", ram_mem[1][2], 8'h07);
        check("tp1_s2", s_mem[1][2], 8'h03);
        check("tp1_s3", s_mem[1][3], 8'h05);
        check("tp1_s5", s_mem[1][5], 8'h02);

        // Printable text on the checked unit at RD_LAT=2.
        identity_s();
        ld_rom[0] = 8'h63; ld_rom[1] = 8'h25; ld_rom[2] = 8'h7D;
        load(0);
        run(0, 3, 1'b0);
        check("tp2_cycle", last_cycle, 40);
        check("tp2_ram", {ram_mem[0][0], ram_mem[0][1], ram_mem[0][2]}, 24'h61207A);
        check("tp2_valid", a_valid, 1);

        // Early abort at k=1.
        identity_s();
        ld_rom[0] = 8'h63; ld_rom[1] = 8'h7E; ld_rom[2] = 8'h7D;
        load(0);
        run(0, 3, 1'b0);
        check("tp3_fail", {a_valid, a_fail}, {1'b0, 5'd1});
        check("tp3_ram", {ram_mem[0][0], ram_mem[0][1]}, 16'h6100);
        check("tp3_cycle", last_cycle, 25);

        // Zero length, then over-length clamp on the unchecked unit.
        run(0, 0, 1'b0);
        check("tp4_cycle", last_cycle, 1);
        random_s();
        for (int x = 0; x < 32; x++) ld_rom[x] = 8'($urandom_range(0, 255));
        load(1);
        run(1, 40, 1'b0);
        check("tp4_clamp", exp_wr, 32);

        // Asynchronous reset during the second byte's WR_J.
        identity_s();
        ld_rom[0] = 8'h63; ld_rom[1] = 8'h25; ld_rom[2] = 8'h7D;
        load(0);
        @(negedge clk);
        start_v[0] = 1'b1;
        len_v[0] = 6'd3;
        begin
            int c;
            c = 0;
            @(negedge clk);
            start_v[0] = 1'b0;
            while (c < 200 && !(a_s_we && a_rom_addr == 5'd1)) begin
                @(negedge clk);
                c++;
            end
            check("rst_reach_wr_j", (c < 200), 1);
        end
        begin
            int swr;
            swr = s_wr_cnt[0];
            #1 rst_n = 1'b0;
            #1;
            check("arst_data", {a_s_addr, a_s_wd, a_ram_wd}, 0);
            check("arst_ctrl", {a_s_we, a_rom_addr, a_ram_addr, a_ram_we, a_busy, a_done, a_valid, a_fail}, 0);
            @(posedge clk);
            #1;
            check("arst_no_write", s_wr_cnt[0] - swr, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        load(0);
        run(0, 3, 1'b0);

        // start held high throughout, then a short follow-up run on live S.
        identity_s();
        load(0);
        build_rom(0, 3, -1);
        load(0);
        run(0, 3, 1'b1);
        run(0, 1, 1'b0);

        // Randomised runs on both units.
        for (int it = 0; it < 12; it++) begin
            g = it % 2;
            random_s();
            for (int x = 0; x < 32; x++) ld_rom[x] = 8'($urandom_range(0, 255));
            load(g);
            len = $urandom_range(0, 40);
            if (g == 0) begin
                bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 31) : -1;
                build_rom(0, len, bad);
                load(0);
            end
            run(g, len, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rc4_prga_stream.md
Name: rc4_prga_stream

Overview:
- Parametrised successor to the fixed 32-byte RC4 PRGA decrypt block.
- Runs the RC4 keystream generator over a pre-scheduled 256-byte S memory and XORs each keystream byte with ciphertext from a ROM.
- Writes plaintext to a result RAM.
- New behaviour over the fixed block:
  - runtime message length
  - configurable memory read latency
  - ROM fetch overlapped with the S[i] read
  - clean i/j/k restart on each start
  - optional printable-character check with early abort, which the key-search controller uses to reject candidate keys.

Parameters:
- MSG_LEN, 32, maximum message length in bytes.
- ADDR_W, 5, ROM/RAM address width; MSG_LEN <= 2**ADDR_W.
- RD_LAT, 2, read latency of S memory and ROM in cycles (1..3).
- CHECK_EN, 1, 1 = abort on a non-printable plaintext byte; 0 = write every byte unchecked.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled in IDLE only
- msg_len  in  ADDR_W+1  bytes to process; sampled with start
- s_read_data  in  8  S memory read data
- rom_read_data  in  8  ciphertext byte
- s_address  out  8  S memory address
- s_write  out  1  S memory write enable
- s_write_data  out  8  S memory write data
- rom_address  out  ADDR_W  ciphertext address (= k)
- ram_address  out  ADDR_W  plaintext address (= k)
- ram_write  out  1  plaintext write enable
- ram_write_data  out  8  plaintext byte
- busy  out  1  high from the first cycle after start is accepted through DONE
- done  out  1  one-cycle pulse at completion
- valid  out  1  result flag; held from DONE until the next accepted start
- fail_index  out  ADDR_W  k of the first rejected byte; 0 when valid=1

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - i, j, k, captured registers, all outputs 0; valid=0.
  - Reset mid-run abandons the run with no further memory writes; memory contents are not restored.
- Start:
  - In IDLE with start=1: latch L = min(msg_len, MSG_LEN) and clear i=j=k=0.
  - If L=0, go straight to DONE with valid=1. Otherwise go to INC_I.
  - start is ignored outside IDLE.
- Per-byte state sequence:
  - INC_I (1 cycle): i <= i+1 mod 256.
  - RD_SI (RD_LAT cycles): s_address=i, rom_address=k. si and romk captured on the last cycle.
  - CALC_J (1 cycle): j <= j+si mod 256.
  - RD_SJ (RD_LAT cycles): s_address=j; sj captured on the last cycle.
  - WR_J (1 cycle): s_address=j, s_write=1, s_write_data=si.
  - WR_I (1 cycle): s_address=i, s_write=1, s_write_data=sj.
  - RD_F (RD_LAT cycles): s_address=(si+sj) mod 256; f captured on the last cycle.
  - CHECK (1 cycle): p=f^romk registered into ram_write_data.
    - If CHECK_EN=1 and p is not in {8'h20, 8'h61..8'h7A}: valid<=0, fail_index<=k, go to DONE. No RAM write occurs.
  - WR_OUT (1 cycle): ram_write=1 at ram_address=k.
  - NEXT (1 cycle): if k==L-1, valid<=1 and go to DONE; else k<=k+1 and go to INC_I.
  - DONE (1 cycle): done=1, then IDLE.
- Per-byte cost is P = 7+3*RD_LAT cycles (13 at RD_LAT=2).
- Latency: with start sampled in cycle 0, done is high in cycle L*P+1 for a full run.
- Memory interface timing:
  - Addresses are held stable throughout each read state.
  - The read address is combinational from state and registers.
  - s_write and ram_write are high only in the write states.
- Widths and wrap:
  - i and j wrap modulo 256.
  - k never exceeds L-1, so it does not wrap.
  - msg_len > MSG_LEN clamps to MSG_LEN.
- Same-address swap: i==j is legal. Both writes go to the same location, and S[i] ends up holding the original value.

Test Plan:
- Identity S (S[x]=x), ROM all 0, CHECK_EN=0, msg_len=3 -> RAM[0..2]=02,05,07; S[2]=3, S[3]=5, S[5]=2; done in cycle 40 (RD_LAT=2); valid=1.
- Identity S, ROM = 63,25,7D, CHECK_EN=1, msg_len=3 -> RAM = 61,20,7A ('a',' ','z'); valid=1; fail_index=0; exactly 3 ram_write pulses.
- Identity S, ROM = 63,7E,7D, CHECK_EN=1 -> abort at k=1: valid=0, fail_index=1; only RAM[0]=61 written; done one cycle after CHECK.
- msg_len=0 -> done in cycle 1, valid=1, no s_write or ram_write; msg_len=40 with MSG_LEN=32 -> exactly 32 RAM writes.
- rst_n pulsed low during the second byte's WR_J -> all outputs 0 immediately (async); busy=0; a following start restarts with i=j=k=0.
- start held high throughout a run, then a second run with msg_len=1 -> start ignored while busy; second run re-reads from i=1/k=0 with cleared indices; RD_LAT=1 build gives done for msg_len=3 in cycle 31.
